// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants, slot type and digit-common decode for the FND scan controller.
package fnd_pkg;
    localparam logic [3:0] COM_OFF = 4'hF;
    localparam int NUM_SLOTS = 8;
    typedef logic [$clog2(NUM_SLOTS)-1:0] slot_t;
    localparam slot_t SLOT_DOT = 3'd6;
    function automatic logic [3:0] com_onehot(input logic [1:0] digit);
        return ~(4'b0001 << digit);
    endfunction
endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// fnd_scan_ctrl_if: scan control bundle; master is the controller, slave is the mux/display side.
interface fnd_scan_ctrl_if;
    import fnd_pkg::*;
    logic en;
    logic [2:0] dim;
    slot_t sel;
    logic [3:0] fnd_com;
    logic slot_tick;
    logic dot_on;
    modport master(input en, dim, output sel, fnd_com, slot_tick, dot_on);
    modport slave(output en, dim, input sel, fnd_com, slot_tick, dot_on);
endinterface

// File: rtl/tick_gen.sv
// tick_gen: modulo-DIV counter advancing while en, with a registered pulse the cycle after it reaches DIV-1.
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    output logic [$clog2(DIV)-1:0]   cnt,
    output logic                     tick
);
    localparam int W = $clog2(DIV);
    if (DIV < 2) begin : g_div_chk
        $error("tick_gen: DIV must be >= 2");
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= en && cnt == W'(DIV - 1);
            if (en) cnt <= (cnt == W'(DIV - 1)) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: 8-slot FND scan controller driving mux select, active-low commons and dot blink.
// Optional PWM dimming is enabled by defining FND_DIM_EN.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int SCAN_HZ     = 8_000,
    parameter int DOT_HZ      = 2
) (
    input logic              clk,
    input logic              rst,
    fnd_scan_ctrl_if.master  bus
);
    localparam int DIV_SCAN = CLK_FREQ_HZ / SCAN_HZ;
    localparam int DIV_DOT  = CLK_FREQ_HZ / (2 * DOT_HZ);
    localparam int SW = $clog2(DIV_SCAN);
    localparam int DW = $clog2(DIV_DOT);
    logic [SW-1:0] scan_cnt;
    logic [DW-1:0] dot_cnt;
    logic slot_tick, unused_dot_tick, wrap, dot_wrap, lit, dot_on;
    slot_t sel;
    logic [3:0] fnd_com;
    tick_gen #(.DIV(DIV_SCAN)) u_slot (
        .clk(clk), .rst(rst), .en(bus.en), .cnt(scan_cnt), .tick(slot_tick)
    );
    tick_gen #(.DIV(DIV_DOT)) u_dot (
        .clk(clk), .rst(rst), .en(1'b1), .cnt(dot_cnt), .tick(unused_dot_tick)
    );
    // wrap is the edge on which slot_tick rises, so sel advances in lockstep with it
    assign wrap     = bus.en && scan_cnt == SW'(DIV_SCAN - 1);
    assign dot_wrap = dot_cnt == DW'(DIV_DOT - 1);
`ifdef FND_DIM_EN
    logic [2:0] dim_q;
    always_ff @(posedge clk) begin
        if (rst) dim_q <= 3'd7;
        else if (wrap) dim_q <= bus.dim;
    end
    // fnd_com is registered, so test the counter value it will be displayed alongside
    assign lit = (int'(scan_cnt) + 1) < (((int'(dim_q) + 1) * DIV_SCAN) >> 3);
`else
    logic unused_dim;
    assign unused_dim = ^bus.dim;
    assign lit = 1'b1;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            sel     <= '0;
            fnd_com <= COM_OFF;
            dot_on  <= 1'b0;
        end else begin
            if (wrap) sel <= sel + 1'b1;
            fnd_com <= (!bus.en || wrap || !lit) ? COM_OFF : com_onehot(sel[1:0]);
            if (dot_wrap) dot_on <= ~dot_on;
        end
    end
    assign bus.sel       = sel;
    assign bus.fnd_com   = fnd_com;
    assign bus.slot_tick = slot_tick;
    assign bus.dot_on    = dot_on;
endmodule
